// File: rtl/com_bus_arbiter_if.sv
// Bus-side signal bundle of the coherence bus arbiter: requests, grants and invalidation status.
// The arbiter connects through the slave modport, and the requesting caches connect through the master modport.
interface com_bus_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0] Com_Bus_Req_proc;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_proc;
    logic [NUM_CORES-1:0] Com_Bus_Req_snoop;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop;
    logic [NUM_CORES-1:0] Invalidation_done;
    logic                 All_Invalidation_done;
    logic                 hold_timeout;

    modport master (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        output Invalidation_done,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  All_Invalidation_done,
        input  hold_timeout
    );

    modport slave (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        input  Invalidation_done,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output All_Invalidation_done,
        output hold_timeout
    );
endinterface

// File: rtl/com_bus_arbiter.sv
// Coherence bus arbiter: a round-robin processor-side grant and an independent round-robin snoop-side grant.
// It also merges the per-core invalidation acknowledges and flags any grant that has been held too long.
module com_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 255
) (
    input  logic             clk,
    input  logic             rst,
    com_bus_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]     HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [NUM_CORES-1:0] ALL_ONES = {NUM_CORES{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    arb_state_t           proc_state_r;
    arb_state_t           snoop_state_r;
    logic [NUM_CORES-1:0] gnt_proc_r;
    logic [NUM_CORES-1:0] gnt_snoop_r;
    logic [PTR_W-1:0]     ptr_proc_r;
    logic [PTR_W-1:0]     ptr_snoop_r;
    logic [PTR_W-1:0]     owner_proc_r;
    logic [PTR_W-1:0]     owner_snoop_r;
    logic [CNT_W-1:0]     hold_proc_r;
    logic [CNT_W-1:0]     hold_snoop_r;
    logic                 all_inv_done_r;
    logic                 hold_timeout_r;

    logic [NUM_CORES-1:0] req_proc_s;
    logic [NUM_CORES-1:0] req_snoop_s;
    logic [NUM_CORES-1:0] inv_done_s;
    logic [NUM_CORES-1:0] pick_proc_s;
    logic [NUM_CORES-1:0] pick_snoop_s;
    logic                 proc_issue_s;
    logic                 proc_release_s;
    logic                 snoop_issue_s;
    logic                 snoop_release_s;
    logic                 proc_tmo_s;
    logic                 snoop_tmo_s;

    // First set bit of req at or after ptr, searched cyclically; zero when req is empty.
    function automatic logic [NUM_CORES-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                     input logic [PTR_W-1:0]     ptr);
        logic [NUM_CORES-1:0] pick;
        logic [PTR_W-1:0]     idx;
        pick = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx  = PTR_W'((int'(ptr) + k) % NUM_CORES);
            pick = req[idx] ? (NUM_CORES'(1) << idx) : pick;
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_CORES-1:0] vec);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = vec[i] ? PTR_W'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] owner);
        return (owner == PTR_W'(NUM_CORES - 1)) ? PTR_W'(0) : owner + PTR_W'(1);
    endfunction

    // Input cleanup: only a definite 1 counts, so X/Z on a request line reads as idle in simulation.
    always_comb begin
        req_proc_s  = '0;
        req_snoop_s = '0;
        inv_done_s  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.Com_Bus_Req_proc[i] == 1'b1) req_proc_s[i] = 1'b1;
            else                                 req_proc_s[i] = 1'b0;
            if (bus.Com_Bus_Req_snoop[i] == 1'b1) req_snoop_s[i] = 1'b1;
            else                                  req_snoop_s[i] = 1'b0;
            if (bus.Invalidation_done[i] == 1'b1) inv_done_s[i] = 1'b1;
            else                                  inv_done_s[i] = 1'b0;
        end
    end

    // Arbitration decisions. Each side masks cores that the other side holds or is granting
    // on this edge, so that the two grants never name the same core.
    always_comb begin
        pick_proc_s    = rr_pick(req_proc_s & ~gnt_snoop_r, ptr_proc_r);
        proc_issue_s   = (proc_state_r == ST_IDLE) && (pick_proc_s != '0);
        proc_release_s = (proc_state_r == ST_BUSY) && ((req_proc_s & gnt_proc_r) == '0);
        if (proc_issue_s) begin
            pick_snoop_s = rr_pick(req_snoop_s & ~gnt_proc_r & ~pick_proc_s, ptr_snoop_r);
        end else begin
            pick_snoop_s = rr_pick(req_snoop_s & ~gnt_proc_r, ptr_snoop_r);
        end
        snoop_issue_s   = (snoop_state_r == ST_IDLE) && (pick_snoop_s != '0);
        snoop_release_s = (snoop_state_r == ST_BUSY) && ((req_snoop_s & gnt_snoop_r) == '0);
        proc_tmo_s  = (proc_state_r == ST_BUSY) && !proc_release_s &&
                      (hold_proc_r == HOLD_MAX - CNT_W'(1));
        snoop_tmo_s = (snoop_state_r == ST_BUSY) && !snoop_release_s &&
                      (hold_snoop_r == HOLD_MAX - CNT_W'(1));
    end

    // Processor-side FSM: grant, hold while the owner keeps requesting, then rotate the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            proc_state_r <= ST_IDLE;
            gnt_proc_r   <= '0;
            ptr_proc_r   <= '0;
            owner_proc_r <= '0;
            hold_proc_r  <= '0;
        end else begin
            case (proc_state_r)
                ST_IDLE: begin
                    if (proc_issue_s) begin
                        proc_state_r <= ST_BUSY;
                        gnt_proc_r   <= pick_proc_s;
                        owner_proc_r <= onehot_idx(pick_proc_s);
                        hold_proc_r  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (proc_release_s) begin
                        proc_state_r <= ST_IDLE;
                        gnt_proc_r   <= '0;
                        ptr_proc_r   <= next_ptr(owner_proc_r);
                    end else if (hold_proc_r != HOLD_MAX) begin
                        hold_proc_r <= hold_proc_r + CNT_W'(1);
                    end
                end
                default: begin
                    proc_state_r <= ST_IDLE;
                    gnt_proc_r   <= '0;
                end
            endcase
        end
    end

    // Snoop-side FSM: same structure as the processor side, with its own pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            snoop_state_r <= ST_IDLE;
            gnt_snoop_r   <= '0;
            ptr_snoop_r   <= '0;
            owner_snoop_r <= '0;
            hold_snoop_r  <= '0;
        end else begin
            case (snoop_state_r)
                ST_IDLE: begin
                    if (snoop_issue_s) begin
                        snoop_state_r <= ST_BUSY;
                        gnt_snoop_r   <= pick_snoop_s;
                        owner_snoop_r <= onehot_idx(pick_snoop_s);
                        hold_snoop_r  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (snoop_release_s) begin
                        snoop_state_r <= ST_IDLE;
                        gnt_snoop_r   <= '0;
                        ptr_snoop_r   <= next_ptr(owner_snoop_r);
                    end else if (hold_snoop_r != HOLD_MAX) begin
                        hold_snoop_r <= hold_snoop_r + CNT_W'(1);
                    end
                end
                default: begin
                    snoop_state_r <= ST_IDLE;
                    gnt_snoop_r   <= '0;
                end
            endcase
        end
    end

    // Status outputs: invalidation acknowledge is computed against the owner that holds the grant now.
    always_ff @(posedge clk) begin
        if (rst) begin
            all_inv_done_r <= 1'b0;
            hold_timeout_r <= 1'b0;
        end else begin
            all_inv_done_r <= (proc_state_r == ST_BUSY) && ((inv_done_s | gnt_proc_r) == ALL_ONES);
            hold_timeout_r <= proc_tmo_s | snoop_tmo_s;
        end
    end

    assign bus.Com_Bus_Gnt_proc      = gnt_proc_r;
    assign bus.Com_Bus_Gnt_snoop     = gnt_snoop_r;
    assign bus.All_Invalidation_done = all_inv_done_r;
    assign bus.hold_timeout          = hold_timeout_r;
endmodule
